// File: rtl/highway_fsm.sv
// Highway side of a highway/country-road crossing: green/yellow/red sequencing,
// a saturating phase countdown, a latched country-road request and a one-cycle grant.
module highway_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       car,
    input  logic       enable_h,
    input  logic [5:0] green_min,
    input  logic [5:0] yellow_len,
    output logic       enable_n,
    output logic [2:0] light_h,
    output logic [5:0] time_left,
    output logic       car_req
);

    // The state encoding is the lamp pattern itself, so light_h also serves as the state probe.
    typedef enum logic [2:0] {
        GREEN_H  = 3'b100,
        YELLOW_H = 3'b010,
        RED_H    = 3'b001
    } state_t;

    state_t     state;
    logic [5:0] cnt;

    // A zero duration still has to show the lamp for one cycle.
    function automatic logic [5:0] phase_len(input logic [5:0] len);
        return (len == 6'd0) ? 6'd1 : len;
    endfunction

    // Handshake with the country-road controller: enable_n is a single-cycle grant
    // issued on entry to RED_H; enable_h is the return grant, only honoured after that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GREEN_H;
            cnt      <= phase_len(green_min);
            enable_n <= 1'b0;
            car_req  <= 1'b0;
        end else begin
            enable_n <= 1'b0;
            if (car)
                car_req <= 1'b1;

            case (state)
                GREEN_H: begin
                    if (cnt == 6'd1 && (car_req || car)) begin
                        state   <= YELLOW_H;
                        cnt     <= phase_len(yellow_len);
                        car_req <= 1'b0;
                    end else if (cnt > 6'd1) begin
                        cnt <= cnt - 6'd1;
                    end
                end
                YELLOW_H: begin
                    if (cnt == 6'd1) begin
                        state    <= RED_H;
                        cnt      <= 6'd0;
                        enable_n <= 1'b1;
                    end else if (cnt > 6'd1) begin
                        cnt <= cnt - 6'd1;
                    end
                end
                RED_H: begin
                    cnt <= 6'd0;
                    if (enable_h && !enable_n) begin
                        state <= GREEN_H;
                        cnt   <= phase_len(green_min);
                    end
                end
                default: begin
                    state <= GREEN_H;
                    cnt   <= phase_len(green_min);
                end
            endcase
        end
    end

    assign light_h   = state;
    assign time_left = cnt;

endmodule

// File: tb/tb_highway_fsm.sv
// Directed bench for highway_fsm: phase lengths, request latching, grant handshake, reset abort.
module tb_highway_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       car;
    logic       enable_h;
    logic [5:0] green_min;
    logic [5:0] yellow_len;
    logic       enable_n;
    logic [2:0] light_h;
    logic [5:0] time_left;
    logic       car_req;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] L_GREEN  = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_RED    = 3'b001;

    highway_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .car        (car),
        .enable_h   (enable_h),
        .green_min  (green_min),
        .yellow_len (yellow_len),
        .enable_n   (enable_n),
        .light_h    (light_h),
        .time_left  (time_left),
        .car_req    (car_req)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are observed and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; car = 1'b0; enable_h = 1'b0;
        green_min = 6'd5; yellow_len = 6'd3;
        step();
        step();
        n_checks++;
        if (light_h !== L_GREEN) begin n_fail++; $display("FAIL reset_light: got %b want %b", light_h, L_GREEN); end
        n_checks++;
        if (time_left !== 6'd5) begin n_fail++; $display("FAIL reset_time: got %0d want 5", time_left); end
        n_checks++;
        if (enable_n !== 1'b0 || car_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got enable_n=%b car_req=%b want 0 0", enable_n, car_req);
        end
    endtask

    // green_min=5, car held: 5 green cycles counting 5..1, then yellow with the request cleared.
    task automatic test_green_min_car();
        rst = 1'b0; car = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (light_h !== L_GREEN || time_left !== 6'(5 - i)) begin
                n_fail++; $display("FAIL green5_cycle%0d: got light=%b time=%0d want light=100 time=%0d", i + 1, light_h, time_left, 5 - i);
            end
        end
        step();
        n_checks++;
        if (light_h !== L_YELLOW || time_left !== 6'd3) begin
            n_fail++; $display("FAIL green5_to_yellow: got light=%b time=%0d want light=010 time=3", light_h, time_left);
        end
        n_checks++;
        if (car_req !== 1'b0) begin n_fail++; $display("FAIL car_req_clear_wins: got %b want 0", car_req); end
        car = 1'b0;
    endtask

    // yellow_len=3: 3 yellow cycles, then red with a single-cycle enable_n.
    task automatic test_yellow();
        step();
        n_checks++;
        if (light_h !== L_YELLOW || time_left !== 6'd2) begin
            n_fail++; $display("FAIL yellow_cycle2: got light=%b time=%0d want light=010 time=2", light_h, time_left);
        end
        step();
        n_checks++;
        if (light_h !== L_YELLOW || time_left !== 6'd1) begin
            n_fail++; $display("FAIL yellow_cycle3: got light=%b time=%0d want light=010 time=1", light_h, time_left);
        end
        step();
        n_checks++;
        if (light_h !== L_RED || enable_n !== 1'b1 || time_left !== 6'd0) begin
            n_fail++; $display("FAIL red_entry: got light=%b en_n=%b time=%0d want light=001 en_n=1 time=0", light_h, enable_n, time_left);
        end
    endtask

    // enable_h on the first red cycle is ignored; a later pulse returns to green.
    task automatic test_red_handshake();
        enable_h = 1'b1;
        step();
        n_checks++;
        if (light_h !== L_RED || enable_n !== 1'b0 || time_left !== 6'd0) begin
            n_fail++; $display("FAIL red_ignore_first: got light=%b en_n=%b time=%0d want light=001 en_n=0 time=0", light_h, enable_n, time_left);
        end
        enable_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (light_h !== L_RED || enable_n !== 1'b0) begin
                n_fail++; $display("FAIL red_hold_%0d: got light=%b en_n=%b want light=001 en_n=0", i, light_h, enable_n);
            end
        end
        enable_h = 1'b1;
        green_min = 6'd8;
        step();
        n_checks++;
        if (light_h !== L_GREEN || time_left !== 6'd8) begin
            n_fail++; $display("FAIL red_to_green: got light=%b time=%0d want light=100 time=8", light_h, time_left);
        end
        enable_h = 1'b0;
    endtask

    // green_min=8 with a one-cycle car pulse at green cycle 2: request latched until yellow.
    task automatic test_car_pulse();
        step();
        car = 1'b1;
        step();
        car = 1'b0;
        n_checks++;
        if (car_req !== 1'b1 || time_left !== 6'd6) begin
            n_fail++; $display("FAIL car_latch: got car_req=%b time=%0d want car_req=1 time=6", car_req, time_left);
        end
        for (int c = 4; c <= 8; c++) begin
            step();
            n_checks++;
            if (light_h !== L_GREEN || car_req !== 1'b1 || time_left !== 6'(9 - c)) begin
                n_fail++; $display("FAIL green8_cycle%0d: got light=%b req=%b time=%0d want light=100 req=1 time=%0d", c, light_h, car_req, time_left, 9 - c);
            end
        end
        step();
        n_checks++;
        if (light_h !== L_YELLOW || car_req !== 1'b0 || time_left !== 6'd3) begin
            n_fail++; $display("FAIL green8_to_yellow: got light=%b req=%b time=%0d want light=010 req=0 time=3", light_h, car_req, time_left);
        end
        step();
        step();
        step();
        n_checks++;
        if (light_h !== L_RED || enable_n !== 1'b1) begin
            n_fail++; $display("FAIL green8_red: got light=%b en_n=%b want light=001 en_n=1", light_h, enable_n);
        end
    endtask

    // Zero durations behave as one cycle each and never wrap the counter.
    task automatic test_zero_lengths();
        green_min = 6'd0; yellow_len = 6'd0;
        step();
        enable_h = 1'b1;
        step();
        enable_h = 1'b0;
        car = 1'b1;
        n_checks++;
        if (light_h !== L_GREEN || time_left !== 6'd1) begin
            n_fail++; $display("FAIL zero_green: got light=%b time=%0d want light=100 time=1", light_h, time_left);
        end
        step();
        car = 1'b0;
        n_checks++;
        if (light_h !== L_YELLOW || time_left !== 6'd1) begin
            n_fail++; $display("FAIL zero_yellow: got light=%b time=%0d want light=010 time=1", light_h, time_left);
        end
        step();
        n_checks++;
        if (light_h !== L_RED || enable_n !== 1'b1 || time_left !== 6'd0) begin
            n_fail++; $display("FAIL zero_red: got light=%b en_n=%b time=%0d want light=001 en_n=1 time=0", light_h, enable_n, time_left);
        end
        step();
        n_checks++;
        if (enable_n !== 1'b0 || time_left === 6'd63) begin
            n_fail++; $display("FAIL zero_after: got en_n=%b time=%0d want en_n=0 time=0", enable_n, time_left);
        end
    endtask

    // Reset during yellow at time_left=2 aborts straight to green without a grant.
    task automatic test_reset_in_yellow();
        green_min = 6'd4; yellow_len = 6'd4;
        enable_h = 1'b1;
        step();
        enable_h = 1'b0;
        car = 1'b1;
        step(); step(); step(); step();
        n_checks++;
        if (light_h !== L_YELLOW || time_left !== 6'd4) begin
            n_fail++; $display("FAIL ry_yellow: got light=%b time=%0d want light=010 time=4", light_h, time_left);
        end
        step(); step();
        n_checks++;
        if (time_left !== 6'd2 || car_req !== 1'b1) begin
            n_fail++; $display("FAIL ry_pre_reset: got time=%0d req=%b want time=2 req=1", time_left, car_req);
        end
        rst = 1'b1; car = 1'b0;
        step();
        n_checks++;
        if (light_h !== L_GREEN || enable_n !== 1'b0 || car_req !== 1'b0 || time_left !== 6'd4) begin
            n_fail++; $display("FAIL ry_reset: got light=%b en_n=%b req=%b time=%0d want light=100 en_n=0 req=0 time=4", light_h, enable_n, car_req, time_left);
        end
        rst = 1'b0;
    endtask

    // With no request, green saturates at 1 and ignores enable_h.
    task automatic test_green_hold();
        enable_h = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (light_h !== L_GREEN || enable_n !== 1'b0 || time_left !== ((i < 3) ? 6'(3 - i) : 6'd1)) begin
                n_fail++; $display("FAIL green_hold_%0d: got light=%b en_n=%b time=%0d", i, light_h, enable_n, time_left);
            end
        end
        enable_h = 1'b0;
    endtask

    initial begin
        test_reset();
        test_green_min_car();
        test_yellow();
        test_red_handshake();
        test_car_pulse();
        test_zero_lengths();
        test_reset_in_yellow();
        test_green_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
